// File: rtl/alu_exec_if.sv
// Instruction and writeback bus of the alu_exec execution unit.
// The master side (fetch/debug) presents instructions; the slave side reports results.
interface alu_exec_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        halt;
    logic [4:0]  dbg_sel;
    logic [31:0] dbg_data;

    modport master (
        output instr_valid, instr, dbg_sel,
        input  instr_ready, wb_valid, wb_rd, wb_data, halt, dbg_data
    );

    modport slave (
        input  instr_valid, instr, dbg_sel,
        output instr_ready, wb_valid, wb_rd, wb_data, halt, dbg_data
    );
endinterface

// File: rtl/alu_exec.sv
// Single-issue RV32I integer execution unit (ALU reg/imm, LUI, SYSTEM halt) with a
// 32x32 register file; shifts run serially or through a barrel shifter.
module alu_exec #(
    parameter bit SHIFT_SERIAL = 1'b1
) (
    input  logic      clk,
    input  logic      resetn,
    alu_exec_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2,
        WB    = 2'd3
    } state_t;

    localparam logic [6:0] OP_ALUR = 7'b0110011;
    localparam logic [6:0] OP_ALUI = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] instr_r;
    logic [31:0] regs_r [32];
    logic [31:0] shift_r;
    logic [4:0]  shift_cnt_r;
    logic        shift_left_r;
    logic        shift_arith_r;
    logic        wb_valid_r;
    logic [4:0]  wb_rd_r;
    logic [31:0] wb_data_r;
    logic        halt_r;

    logic        accept_s;
    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic        alt_s;
    logic [31:0] rs1_val_s;
    logic [31:0] rs2_val_s;
    logic [31:0] op_b_s;
    logic [4:0]  shamt_s;
    logic        is_alu_s;
    logic        is_shift_s;
    logic [31:0] alu_s;
    logic [31:0] exec_result_s;
    logic [31:0] shift_next_s;

    assign bus.instr_ready = (state_r == IDLE) && !halt_r;
    assign accept_s        = bus.instr_valid && bus.instr_ready;
    assign bus.wb_valid    = wb_valid_r;
    assign bus.wb_rd       = wb_rd_r;
    assign bus.wb_data     = wb_data_r;
    assign bus.halt        = halt_r;
    assign bus.dbg_data    = (bus.dbg_sel == 5'd0) ? 32'd0 : regs_r[bus.dbg_sel];

    // Decode the latched instruction and fetch its operands.
    always_comb begin
        opcode_s  = instr_r[6:0];
        funct3_s  = instr_r[14:12];
        alt_s     = instr_r[30];
        rs1_val_s = (instr_r[19:15] == 5'd0) ? 32'd0 : regs_r[instr_r[19:15]];
        rs2_val_s = (instr_r[24:20] == 5'd0) ? 32'd0 : regs_r[instr_r[24:20]];
        is_alu_s  = (opcode_s == OP_ALUR) || (opcode_s == OP_ALUI);
        if (opcode_s == OP_ALUR) begin
            op_b_s = rs2_val_s;
        end else begin
            op_b_s = {{20{instr_r[31]}}, instr_r[31:20]};
        end
        // For immediates the low five bits of op_b are instr[24:20], the shamt field.
        shamt_s    = op_b_s[4:0];
        is_shift_s = is_alu_s && (funct3_s[1:0] == 2'b01);
    end

    // Single-cycle ALU; in serial mode shifts only reach here with amount zero.
    always_comb begin
        alu_s = 32'd0;
        case (funct3_s)
            3'b000: begin
                if ((opcode_s == OP_ALUR) && alt_s) begin
                    alu_s = rs1_val_s - op_b_s;
                end else begin
                    alu_s = rs1_val_s + op_b_s;
                end
            end
            3'b001: begin
                if (SHIFT_SERIAL) begin
                    alu_s = rs1_val_s;
                end else begin
                    alu_s = rs1_val_s << shamt_s;
                end
            end
            3'b010:  alu_s = {31'd0, $signed(rs1_val_s) < $signed(op_b_s)};
            3'b011:  alu_s = {31'd0, rs1_val_s < op_b_s};
            3'b100:  alu_s = rs1_val_s ^ op_b_s;
            3'b101: begin
                if (SHIFT_SERIAL) begin
                    alu_s = rs1_val_s;
                end else if (alt_s) begin
                    alu_s = $unsigned($signed(rs1_val_s) >>> shamt_s);
                end else begin
                    alu_s = rs1_val_s >> shamt_s;
                end
            end
            3'b110:  alu_s = rs1_val_s | op_b_s;
            3'b111:  alu_s = rs1_val_s & op_b_s;
            default: alu_s = 32'd0;
        endcase
        if (opcode_s == OP_LUI) begin
            exec_result_s = {instr_r[31:12], 12'd0};
        end else begin
            exec_result_s = alu_s;
        end
    end

    // One-bit step of the serial shifter; arithmetic right keeps replicating bit 31.
    always_comb begin
        if (shift_left_r) begin
            shift_next_s = {shift_r[30:0], 1'b0};
        end else if (shift_arith_r) begin
            shift_next_s = {shift_r[31], shift_r[31:1]};
        end else begin
            shift_next_s = {1'b0, shift_r[31:1]};
        end
    end

    // Next-state logic of the control FSM.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = EXEC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            EXEC: begin
                if (is_alu_s) begin
                    if (SHIFT_SERIAL && is_shift_s && (shamt_s != 5'd0)) begin
                        next_state_s = SHIFT;
                    end else begin
                        next_state_s = WB;
                    end
                end else if (opcode_s == OP_LUI) begin
                    next_state_s = WB;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                if (shift_cnt_r <= 5'd1) begin
                    next_state_s = WB;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            WB:      next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Instruction latch, serial shifter, halt flag and registered writeback outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            instr_r       <= 32'd0;
            shift_r       <= 32'd0;
            shift_cnt_r   <= 5'd0;
            shift_left_r  <= 1'b0;
            shift_arith_r <= 1'b0;
            wb_valid_r    <= 1'b0;
            wb_rd_r       <= 5'd0;
            wb_data_r     <= 32'd0;
            halt_r        <= 1'b0;
        end else begin
            wb_valid_r <= (next_state_s == WB);
            if (accept_s) begin
                instr_r <= bus.instr;
            end
            if ((state_r == EXEC) && (opcode_s == OP_SYS)) begin
                halt_r <= 1'b1;
            end
            if ((state_r == EXEC) && (next_state_s == SHIFT)) begin
                shift_r       <= rs1_val_s;
                shift_cnt_r   <= shamt_s;
                shift_left_r  <= (funct3_s == 3'b001);
                shift_arith_r <= alt_s;
            end
            if (state_r == SHIFT) begin
                shift_r     <= shift_next_s;
                shift_cnt_r <= shift_cnt_r - 5'd1;
            end
            if (next_state_s == WB) begin
                wb_rd_r   <= instr_r[11:7];
                wb_data_r <= (state_r == SHIFT) ? shift_next_s : exec_result_s;
            end
        end
    end

    // Register file: committed on the edge that leaves WB, so a reset in WB drops the write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if ((state_r == WB) && (wb_rd_r != 5'd0)) begin
            regs_r[wb_rd_r] <= wb_data_r;
        end
    end
endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed scenarios plus random RV32I ALU traffic
// compared against an architectural model of the register file.
module tb_alu_exec;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    alu_exec_if bus();
    alu_exec #(.SHIFT_SERIAL(1'b1)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] mregs [32];
    logic [31:0] got_v;
    int          pulses_v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, OP_I};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_R};
    endfunction

    // Architectural result of an ALU operation, written from the ISA definitions.
    function automatic logic [31:0] model_alu(input logic [2:0] f3, input logic sub_sel,
                                              input logic sra_sel, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [4:0]  sh;
        logic [31:0] r;
        sh = b[4:0];
        case (f3)
            3'd0: r = sub_sel ? a + (~b + 32'd1) : a + b;
            3'd1: r = a * (32'd1 << sh);
            3'd2: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: begin
                r = a >> sh;
                if (sra_sel && a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        int         kind;
        logic [4:0] rd, r1, r2, sh;
        logic [2:0] f3;
        logic       alt;
        kind = $urandom_range(0, 9);
        rd   = 5'($urandom_range(0, 15));
        r1   = 5'($urandom_range(0, 15));
        r2   = 5'($urandom_range(0, 15));
        sh   = 5'($urandom_range(0, 31));
        f3   = 3'($urandom_range(0, 7));
        alt  = 1'($urandom_range(0, 1));
        case (kind)
            0, 1, 2, 3: return enc_r({1'b0, alt, 5'd0}, r2, r1, f3, rd);
            4, 5, 6: begin
                if (f3 == 3'd1 || f3 == 3'd5) return enc_i({1'b0, alt, 5'd0, sh}, r1, f3, rd);
                return enc_i(12'($urandom), r1, f3, rd);
            end
            7, 8:    return {20'($urandom), rd, OP_LUI};
            default: return {25'($urandom), 7'b0000011};
        endcase
    endfunction

    // Issue one instruction and check writeback timing, value, and register file effect.
    task automatic issue(input logic [31:0] ins, input string tag, output logic [31:0] got);
        logic [6:0]  op;
        logic [4:0]  rd, got_rd;
        logic [31:0] a, b, expd;
        logic        wb_exp;
        int          lat, waitc, pulses, first;
        op = ins[6:0];
        rd = ins[11:7];
        a  = mregs[ins[19:15]];
        if (op == OP_R) b = mregs[ins[24:20]];
        else            b = {{20{ins[31]}}, ins[31:20]};
        wb_exp = 1'b1;
        lat    = 2;
        expd   = 32'd0;
        case (op)
            OP_R, OP_I: begin
                expd = model_alu(ins[14:12], (op == OP_R) && ins[30], ins[30], a, b);
                if (ins[13:12] == 2'b01) lat = 2 + int'(b[4:0]);
            end
            OP_LUI:  expd = {ins[31:12], 12'd0};
            default: wb_exp = 1'b0;
        endcase
        waitc = 0;
        while (bus.instr_ready !== 1'b1 && waitc < 60) begin
            @(negedge clk);
            waitc++;
        end
        check({tag, " ready"}, {31'd0, bus.instr_ready}, 32'd1);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        pulses = 0;
        first  = 0;
        got    = 32'd0;
        got_rd = 5'd0;
        for (int k = 1; k <= lat + 2; k++) begin
            @(negedge clk);
            if (op == OP_SYS && k == 2) begin
                check({tag, " halt"}, {31'd0, bus.halt}, 32'd1);
                check({tag, " ready_low"}, {31'd0, bus.instr_ready}, 32'd0);
            end
            if (bus.wb_valid === 1'b1) begin
                pulses++;
                if (first == 0) begin
                    first  = k;
                    got    = bus.wb_data;
                    got_rd = bus.wb_rd;
                end
            end
        end
        check({tag, " pulses"}, 32'(pulses), wb_exp ? 32'd1 : 32'd0);
        if (wb_exp) begin
            check({tag, " latency"}, 32'(first), 32'(lat));
            check({tag, " wb_rd"}, {27'd0, got_rd}, {27'd0, rd});
            check({tag, " wb_data"}, got, expd);
            check({tag, " wb_hold"}, bus.wb_data, expd);
            if (rd != 5'd0) mregs[rd] = expd;
        end
        bus.dbg_sel = rd;
        #1;
        check({tag, " dbg"}, bus.dbg_data, mregs[rd]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn          = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        bus.dbg_sel     = 5'd1;
        clear_model();
        repeat (2) @(negedge clk);
        check("rst wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        check("rst wb_rd", {27'd0, bus.wb_rd}, 32'd0);
        check("rst wb_data", bus.wb_data, 32'd0);
        check("rst halt", {31'd0, bus.halt}, 32'd0);
        check("rst ready", {31'd0, bus.instr_ready}, 32'd1);
        check("rst dbg x1", bus.dbg_data, 32'd0);
        resetn = 1'b1;

        issue(enc_i(12'd5, 5'd0, 3'd0, 5'd1), "addi x1", got_v);
        check("spec addi x1", got_v, 32'd5);
        issue(enc_i(12'd7, 5'd0, 3'd0, 5'd0), "addi x0", got_v);
        check("spec addi x0", got_v, 32'd7);
        issue(enc_i(12'hFFD, 5'd0, 3'd0, 5'd2), "addi x2", got_v);
        issue(enc_r(7'd0, 5'd1, 5'd2, 3'd2, 5'd3), "slt", got_v);
        check("spec slt", got_v, 32'd1);
        issue(enc_r(7'd0, 5'd1, 5'd2, 3'd3, 5'd4), "sltu", got_v);
        check("spec sltu", got_v, 32'd0);
        issue(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd5), "sub", got_v);
        check("spec sub", got_v, 32'd8);
        issue({20'hABCDE, 5'd6, OP_LUI}, "lui x6", got_v);
        check("spec lui", got_v, 32'hABCD_E000);
        issue({20'h80000, 5'd2, OP_LUI}, "lui x2", got_v);
        issue(enc_i(12'h41F, 5'd2, 3'd5, 5'd7), "srai31", got_v);
        check("spec srai31", got_v, 32'hFFFF_FFFF);
        issue(enc_i(12'd0, 5'd2, 3'd1, 5'd8), "slli0", got_v);
        check("spec slli0", got_v, 32'h8000_0000);
        issue(enc_i(12'd4, 5'd2, 3'd5, 5'd9), "srli4", got_v);
        check("spec srli4", got_v, 32'h0800_0000);

        for (int i = 0; i < 40; i++) begin
            issue(rand_instr(), "random", got_v);
        end

        issue(32'h0010_0073, "ebreak", got_v);
        bus.instr       = enc_i(12'd9, 5'd0, 3'd0, 5'd1);
        bus.instr_valid = 1'b1;
        pulses_v        = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.wb_valid === 1'b1) pulses_v++;
        end
        bus.instr_valid = 1'b0;
        check("halted no wb", 32'(pulses_v), 32'd0);
        check("halt sticky", {31'd0, bus.halt}, 32'd1);
        bus.dbg_sel = 5'd1;
        #1;
        check("halted x1", bus.dbg_data, mregs[1]);

        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        clear_model();
        issue({20'h80000, 5'd2, OP_LUI}, "lui x2 again", got_v);
        bus.instr       = enc_i(12'h41F, 5'd2, 3'd5, 5'd7);
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        pulses_v = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.wb_valid === 1'b1) pulses_v++;
        end
        #2;
        resetn = 1'b0;
        #1;
        check("async wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        check("async wb_rd", {27'd0, bus.wb_rd}, 32'd0);
        check("async wb_data", bus.wb_data, 32'd0);
        check("async halt", {31'd0, bus.halt}, 32'd0);
        bus.dbg_sel = 5'd2;
        #1;
        check("async x2", bus.dbg_data, 32'd0);
        bus.dbg_sel = 5'd7;
        #1;
        check("async x7", bus.dbg_data, 32'd0);
        clear_model();
        repeat (3) begin
            @(negedge clk);
            if (bus.wb_valid === 1'b1) pulses_v++;
        end
        resetn = 1'b1;
        #1;
        check("post rst ready", {31'd0, bus.instr_ready}, 32'd1);
        check("aborted no wb", 32'(pulses_v), 32'd0);
        issue(enc_i(12'd1, 5'd0, 3'd0, 5'd1), "addi after rst", got_v);
        check("spec addi after rst", got_v, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHIFT_SERIAL, default 1: 1 = shifts execute one bit per cycle; 0 = single-cycle barrel shift.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 instr_valid  input  1  fetch stage presents an instruction.
REQ-005 instr  input  32  RV32I instruction word.
REQ-006 instr_ready  output  1  block accepts instr this cycle.
REQ-007 wb_valid  output  1  one-cycle pulse: result available.
REQ-008 wb_rd  output  5  destination register of the result.
REQ-009 wb_data  output  32  result value.
REQ-010 halt  output  1  sticky; SYSTEM opcode executed.
REQ-011 dbg_sel  input  5  debug register select.
REQ-012 dbg_data  output  32  combinational read of register dbg_sel; x0 reads 0.

Function
REQ-013 Contains a 32x32 register file; x0 always reads 0; writes to x0 are discarded.
REQ-014 States: IDLE, EXEC, SHIFT, WB.
REQ-015 instr_ready = (state==IDLE) && !halt.
REQ-016 Handshake: instr is accepted on a rising edge with instr_valid && instr_ready; instr latched internally; IDLE->EXEC.
REQ-017 instr_valid while instr_ready=0 is ignored; no instruction is queued.
REQ-018 EXEC: reads rs1 (instr[19:15]) and rs2 (instr[24:20]) from the register file and decodes opcode instr[6:0].
REQ-019 Opcode 0110011 (ALUR): funct3 000 add, or sub if instr[30]=1; 001 sll; 010 slt (signed); 011 sltu; 100 xor; 101 srl, or sra if instr[30]=1; 110 or; 111 and; shift amount rs2[4:0].
REQ-020 Opcode 0010011 (ALUI): same funct3 map with operand B = sign-extended instr[31:20]; funct3 000 always add; shift amount instr[24:20]; instr[30] selects srai.
REQ-021 Opcode 0110111 (LUI): result = {instr[31:12], 12'b0}.
REQ-022 Opcode 1110011 (SYSTEM): halt set at the end of EXEC; no writeback; EXEC->IDLE; halt holds until reset.
REQ-023 All other opcodes: no writeback, no state change; EXEC->IDLE.
REQ-024 All arithmetic is modulo 2^32; slt/sltu results are 0 or 1, zero-extended.
REQ-025 Shift with SHIFT_SERIAL=1 and amount >0: EXEC->SHIFT; a 5-bit counter loads the amount; shift one bit per cycle until the counter reaches 0; then SHIFT->WB; sra fills with the original bit 31.
REQ-026 Shift amount 0 or SHIFT_SERIAL=0: EXEC->WB directly.
REQ-027 WB: wb_valid=1 for exactly one cycle; wb_rd=instr[11:7]; wb_data=result; the register file is written the same edge unless rd=0; WB->IDLE.
REQ-028 wb_valid is also asserted when rd=0, with wb_data = the computed value.
REQ-029 Latency: accept edge N -> wb_valid high in cycle N+2 (non-shift); N+2+amount (serial shift).
REQ-030 wb_rd and wb_data hold their last values outside WB.
REQ-031 The next accepted instruction reads the value written in WB; no hazard is possible, since IDLE separates instructions.

Reset
REQ-032 resetn=0 immediately, regardless of clk, forces: state=IDLE, halt=0, wb_valid=0, wb_rd=0, wb_data=0, shift counter=0, all registers=0.
REQ-033 Reset during EXEC/SHIFT/WB aborts the instruction with no register write; instr_ready=1 on the first cycle after release.

Verification
REQ-034 Reset, addi x1,x0,5 accepted at edge N -> wb_valid in cycle N+2, wb_rd=1, wb_data=5, dbg_sel=1 gives 5.
REQ-035 addi x0,x0,7 -> wb_valid=1, wb_data=7, dbg_sel=0 gives 0.
REQ-036 x1=5, x2=-3: slt x3,x2,x1 -> 1; sltu x4,x2,x1 -> 0; sub x5,x1,x2 -> 8; lui x6,0xABCDE -> 0xABCDE000.
REQ-037 SHIFT_SERIAL=1, x2=0x80000000: srai x7,x2,31 -> wb_data=0xFFFFFFFF at N+33; slli x8,x2,0 -> 0x80000000 at N+2; srli x9,x2,4 -> 0x08000000 at N+6.
REQ-038 ebreak (0x00100073) -> halt=1 and instr_ready=0 from cycle N+2; instr_valid held high with addi x1,x0,9 -> x1 unchanged, no wb_valid.
REQ-039 resetn pulsed low mid-SHIFT of srai -> all outputs 0 asynchronously, no wb_valid, x7 reads 0; after release addi x1,x0,1 completes normally.
